// File: rtl/vout_pkg.sv
// Shared constants and helpers for the output video timing generator:
// polarity levels, RGB565 colour-bar values and the total-count helper.
package vout_pkg;

   localparam logic POL_HIGH = 1'b1;
   localparam logic POL_LOW  = 1'b0;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/vout_delay_line.sv
// Fixed-depth shift register used to match the frame-buffer read latency.
// Every stage resets to RST_VAL so the drained pipeline shows idle levels.
module vout_delay_line #(
   parameter int               DEPTH   = 1,
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic             video_clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   // Shift one stage per pixel clock.
   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vout_timing_align.sv
// Output video timing generator with read-latency alignment.
// Generates frame-buffer read timing (req_vs_n, req_de), delays hs/vs/de by
// RD_LAT + 1 cycles to line up with returned pixels, blanks outside the
// active area and flags read underflow.
// Optional build macro VOUT_TEST_PATTERN_EN adds pattern_en and an 8-bar
// RGB565 colour pattern in place of frame-buffer data.
module vout_timing_align
   import vout_pkg::*;
#(
   parameter int   H_ACTIVE = 1280,
   parameter int   H_FP     = 110,
   parameter int   H_SYNC   = 40,
   parameter int   H_BP     = 220,
   parameter int   V_ACTIVE = 720,
   parameter int   V_FP     = 5,
   parameter int   V_SYNC   = 5,
   parameter int   V_BP     = 20,
   parameter logic HS_POL   = POL_HIGH,
   parameter logic VS_POL   = POL_HIGH,
   parameter int   PIX_W    = 16,
   parameter int   RD_LAT   = 5,
   parameter int   CNT_W    = 12
)(
   input  logic             video_clk,
   input  logic             rst_n,
   input  logic             enable,
`ifdef VOUT_TEST_PATTERN_EN
   input  logic             pattern_en,
`endif
   output logic             req_vs_n,
   output logic             req_de,
   input  logic             rd_den,
   input  logic [PIX_W-1:0] rd_data,
   output logic             out_hs,
   output logic             out_vs,
   output logic             out_de,
   output logic [PIX_W-1:0] out_data,
   output logic             frame_start,
   output logic             underflow,
   input  logic             underflow_clr
);

   localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             run;
   logic             go;
   logic             h_act, v_act, h_sync_reg, v_sync_reg;
   logic             hs_raw, vs_raw;
   logic             hs_d, vs_d, de_d;
   logic [PIX_W-1:0] data_nxt;
   logic             uf_set;

   // run lags enable by one cycle so a fresh enable parks the counters at
   // (0,0) for one edge before the first decode is registered.
   assign go = enable && run;

   // Pixel/line counters; held at (0,0) whenever timing is not running.
   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         run   <= 1'b0;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         run <= enable;
         if (!go) begin
            h_cnt <= '0;
            v_cnt <= '0;
         end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // Region decode of the current counter position.
   always_comb begin
      h_act      = (h_cnt < H_ACT_END);
      v_act      = (v_cnt < V_ACT_END);
      h_sync_reg = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
      v_sync_reg = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
   end

   // Registered read-request timing and raw syncs.
   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         req_de      <= 1'b0;
         req_vs_n    <= 1'b1;
         frame_start <= 1'b0;
         hs_raw      <= ~HS_POL;
         vs_raw      <= ~VS_POL;
      end else begin
         req_de      <= go && h_act && v_act;
         req_vs_n    <= !(go && v_sync_reg);
         frame_start <= go && (h_cnt == '0) && (v_cnt == '0);
         hs_raw      <= (go && h_sync_reg) ? HS_POL : ~HS_POL;
         vs_raw      <= (go && v_sync_reg) ? VS_POL : ~VS_POL;
      end
   end

   vout_delay_line #(
      .DEPTH   (RD_LAT),
      .WIDTH   (3),
      .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
   ) u_sync_dly (
      .video_clk (video_clk),
      .rst_n     (rst_n),
      .din       ({hs_raw, vs_raw, req_de}),
      .dout      ({hs_d, vs_d, de_d})
   );

`ifdef VOUT_TEST_PATTERN_EN
   logic [CNT_W-1:0] x_raw, x_d;
   logic [2:0]       bar_idx;
   int               bar_full;

   // x-coordinate registered alongside req_de so it shares its latency.
   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) x_raw <= '0;
      else        x_raw <= h_cnt;
   end

   vout_delay_line #(
      .DEPTH   (RD_LAT),
      .WIDTH   (CNT_W),
      .RST_VAL ('0)
   ) u_x_dly (
      .video_clk (video_clk),
      .rst_n     (rst_n),
      .din       (x_raw),
      .dout      (x_d)
   );

   // Pixel select: colour bars when pattern_en, else frame-buffer data.
   always_comb begin
      data_nxt = '0;
      uf_set   = 1'b0;
      bar_full = (int'(x_d) * 8) / H_ACTIVE;
      bar_idx  = (bar_full > 7) ? 3'd7 : bar_full[2:0];
      if (pattern_en) begin
         if (de_d) data_nxt = PIX_W'(bar_color(bar_idx));
      end else begin
         if (de_d && rd_den) data_nxt = rd_data;
         uf_set = de_d && !rd_den;
      end
   end
`else
   // Pixel select: pass frame-buffer data only for valid active pixels.
   always_comb begin
      data_nxt = '0;
      uf_set   = de_d && !rd_den;
      if (de_d && rd_den) data_nxt = rd_data;
   end
`endif

   // Output register; a new underflow beats a simultaneous clear.
   always_ff @(posedge video_clk or negedge rst_n) begin
      if (!rst_n) begin
         out_hs    <= ~HS_POL;
         out_vs    <= ~VS_POL;
         out_de    <= 1'b0;
         out_data  <= '0;
         underflow <= 1'b0;
      end else begin
         out_hs   <= hs_d;
         out_vs   <= vs_d;
         out_de   <= de_d;
         out_data <= data_nxt;
         if (uf_set)             underflow <= 1'b1;
         else if (underflow_clr) underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vout_timing_align.sv
// Directed bench for vout_timing_align: small 14x7 raster, RD_LAT=5, a
// positive-polarity and a negative-polarity instance sharing the stimulus.
module tb_vout_timing_align;

   localparam int PW = 16;

   logic          video_clk;
   logic          rst_n;
   logic          enable;
   logic          rd_den;
   logic [PW-1:0] rd_data;
   logic          underflow_clr;

   logic          req_vs_n_p, req_de_p, out_hs_p, out_vs_p, out_de_p, frame_start_p, underflow_p;
   logic [PW-1:0] out_data_p;
   logic          req_vs_n_n, req_de_n, out_hs_n, out_vs_n, out_de_n, frame_start_n, underflow_n;
   logic [PW-1:0] out_data_n;

   logic [4:0]    hist = '0;
   logic [PW-1:0] pix  = 16'h0100;
   logic          drop = 1'b0;
   logic          force_den = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int blank_err = 0;
   bit pix_en = 0;
   logic [PW-1:0] exp_pix = 16'h0100;
   int c_req_de, c_rvs_p, c_rvs_n, c_out_de, c_hs_p, c_hs_n, c_vs_p, c_vs_n, c_fs;

   vout_timing_align #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIX_W(PW), .RD_LAT(5), .CNT_W(5)
   ) dut_p (
      .video_clk(video_clk), .rst_n(rst_n), .enable(enable),
`ifdef VOUT_TEST_PATTERN_EN
      .pattern_en(1'b0),
`endif
      .req_vs_n(req_vs_n_p), .req_de(req_de_p), .rd_den(rd_den), .rd_data(rd_data),
      .out_hs(out_hs_p), .out_vs(out_vs_p), .out_de(out_de_p), .out_data(out_data_p),
      .frame_start(frame_start_p), .underflow(underflow_p), .underflow_clr(underflow_clr)
   );

   vout_timing_align #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(PW), .RD_LAT(5), .CNT_W(5)
   ) dut_n (
      .video_clk(video_clk), .rst_n(rst_n), .enable(enable),
`ifdef VOUT_TEST_PATTERN_EN
      .pattern_en(1'b0),
`endif
      .req_vs_n(req_vs_n_n), .req_de(req_de_n), .rd_den(rd_den), .rd_data(rd_data),
      .out_hs(out_hs_n), .out_vs(out_vs_n), .out_de(out_de_n), .out_data(out_data_n),
      .frame_start(frame_start_n), .underflow(underflow_n), .underflow_clr(underflow_clr)
   );

   initial video_clk = 1'b0;
   always #5 video_clk = ~video_clk;

   // Frame-buffer model: data valid is req_de delayed 5 cycles, data increments per read.
   assign rd_den  = (hist[4] & ~drop) | force_den;
   assign rd_data = pix;
   always @(posedge video_clk) begin
      hist <= {hist[3:0], req_de_p};
      if (rd_den) pix <= pix + 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_counts();
      c_req_de = 0; c_rvs_p = 0; c_rvs_n = 0; c_out_de = 0;
      c_hs_p = 0; c_hs_n = 0; c_vs_p = 0; c_vs_n = 0; c_fs = 0;
   endtask

   task automatic accum();
      if (req_de_p)      c_req_de++;
      if (!req_vs_n_p)   c_rvs_p++;
      if (!req_vs_n_n)   c_rvs_n++;
      if (out_de_p)      c_out_de++;
      if (out_hs_p)      c_hs_p++;
      if (!out_hs_n)     c_hs_n++;
      if (out_vs_p)      c_vs_p++;
      if (!out_vs_n)     c_vs_n++;
      if (frame_start_p) c_fs++;
      if (out_de_p !== 1'b1 && out_data_p !== '0) blank_err++;
      if (out_de_n !== 1'b1 && out_data_n !== '0) blank_err++;
      if (pix_en && out_de_p) begin
         chk("pixel", 32'(out_data_p), 32'(exp_pix));
         exp_pix = exp_pix + 1'b1;
      end
   endtask

   task automatic step();
      @(posedge video_clk);
      @(negedge video_clk);
      cyc++;
      accum();
   endtask

   task automatic chk_reset_state(input string pfx);
      chk({pfx, "_req_de"},      32'(req_de_p), 0);
      chk({pfx, "_req_vs_n"},    32'(req_vs_n_p), 1);
      chk({pfx, "_req_vs_n_n"},  32'(req_vs_n_n), 1);
      chk({pfx, "_out_hs_p"},    32'(out_hs_p), 0);
      chk({pfx, "_out_vs_p"},    32'(out_vs_p), 0);
      chk({pfx, "_out_hs_n"},    32'(out_hs_n), 1);
      chk({pfx, "_out_vs_n"},    32'(out_vs_n), 1);
      chk({pfx, "_out_de"},      32'(out_de_p), 0);
      chk({pfx, "_out_data"},    32'(out_data_p), 0);
      chk({pfx, "_frame_start"}, 32'(frame_start_p), 0);
      chk({pfx, "_underflow"},   32'(underflow_p), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t_fs1, a, b;
      rst_n = 1'b1; enable = 1'b0; underflow_clr = 1'b0;
      clear_counts();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge video_clk);
      chk_reset_state("rst");

      // Start-up latency and alignment
      rst_n = 1'b1;
      step();
      enable = 1'b1;
      pix_en = 1;
      n = 0;
      do begin step(); n++; end while (!frame_start_p && n < 200);
      chk("fs_first_latency", 32'(n), 2);
      chk("req_de_at_fs", 32'(req_de_p), 1);
      t_fs1 = cyc;
      n = 0;
      while (!out_de_p && n < 20) begin step(); n++; end
      chk("de_align", 32'(n), 6);
      n = 0;
      do begin step(); n++; end while (!frame_start_p && n < 200);
      chk("fs_period", 32'(cyc - t_fs1), 98);

      // One steady-state frame window
      clear_counts();
      accum();
      repeat (97) step();
      chk("frame_req_de",    32'(c_req_de), 32);
      chk("frame_req_vs_n",  32'(c_rvs_p), 14);
      chk("frame_req_vs_nn", 32'(c_rvs_n), 14);
      chk("frame_out_de",    32'(c_out_de), 32);
      chk("frame_hs_pos",    32'(c_hs_p), 14);
      chk("frame_hs_neg",    32'(c_hs_n), 14);
      chk("frame_vs_pos",    32'(c_vs_p), 14);
      chk("frame_vs_neg",    32'(c_vs_n), 14);
      chk("frame_fs_count",  32'(c_fs), 1);
      step();
      chk("fs_period2", 32'(frame_start_p), 1);
      pix_en = 0;
      chk("no_uf_stream", 32'(underflow_p), 0);

      // Underflow
      n = 0;
      while (!hist[4] && n < 200) begin step(); n++; end
      drop = 1'b1;
      step();
      drop = 1'b0;
      chk("uf_out_de", 32'(out_de_p), 1);
      chk("uf_data",   32'(out_data_p), 0);
      chk("uf_flag",   32'(underflow_p), 1);
      repeat (20) step();
      chk("uf_sticky", 32'(underflow_p), 1);
      underflow_clr = 1'b1;
      step();
      underflow_clr = 1'b0;
      chk("uf_clr", 32'(underflow_p), 0);
      n = 0;
      while (hist[4] && n < 200) begin step(); n++; end
      force_den = 1'b1;
      step();
      force_den = 1'b0;
      chk("den_blank_flag", 32'(underflow_p), 0);
      chk("den_blank_data", 32'(out_data_p), 0);
      n = 0;
      while (!hist[4] && n < 200) begin step(); n++; end
      drop = 1'b1; underflow_clr = 1'b1;
      step();
      drop = 1'b0; underflow_clr = 1'b0;
      chk("uf_set_wins", 32'(underflow_p), 1);

      // Disable mid-line, then re-enable
      n = 0;
      while (!req_de_p && n < 200) begin step(); n++; end
      chk("wait_req_de", 32'(req_de_p), 1);
      enable = 1'b0;
      step();
      chk("dis_req_de",   32'(req_de_p), 0);
      chk("dis_req_vs_n", 32'(req_vs_n_p), 1);
      chk("dis_fs",       32'(frame_start_p), 0);
      repeat (5) step();
      chk("dis_last_de", 32'(out_de_p), 1);
      step();
      chk("dis_out_de",   32'(out_de_p), 0);
      chk("dis_out_hs_p", 32'(out_hs_p), 0);
      chk("dis_out_hs_n", 32'(out_hs_n), 1);
      chk("dis_out_vs_p", 32'(out_vs_p), 0);
      chk("dis_out_vs_n", 32'(out_vs_n), 1);
      chk("dis_out_data", 32'(out_data_p), 0);
      repeat (10) step();
      enable = 1'b1;
      n = 0;
      do begin step(); n++; end while (!frame_start_p && n < 50);
      chk("reen_fs_latency", 32'(n), 2);
      a = req_de_p ? 1 : 0;
      repeat (7) begin step(); if (req_de_p) a++; end
      b = 0;
      repeat (6) begin step(); if (req_de_p) b++; end
      chk("reen_line0_active", 32'(a), 8);
      chk("reen_line0_blank",  32'(b), 0);

      // Asynchronous reset mid-frame
      n = 0;
      while (!out_de_p && n < 200) begin step(); n++; end
      chk("wait_de_for_rst", 32'(out_de_p), 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_state("async_rst");
      #1 rst_n = 1'b1;
      repeat (3) step();

      chk("blank_data", 32'(blank_err), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
